// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state type, segment codes and helpers for the reaction timer
package reaction_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, TIMING, DONE, FAULT} state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Segment codes are active-low {dp, g, f, e, d, c, b, a}; dp is always off.
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_I     = 8'hF9;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd_to_sseg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_sseg = 8'hC0;
            4'd1:    bcd_to_sseg = 8'hF9;
            4'd2:    bcd_to_sseg = 8'hA4;
            4'd3:    bcd_to_sseg = 8'hB0;
            4'd4:    bcd_to_sseg = 8'h99;
            4'd5:    bcd_to_sseg = 8'h92;
            4'd6:    bcd_to_sseg = 8'h82;
            4'd7:    bcd_to_sseg = 8'hF8;
            4'd8:    bcd_to_sseg = 8'h80;
            4'd9:    bcd_to_sseg = 8'h90;
            default: bcd_to_sseg = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        int unsigned r;
        r = v;
        to_bcd = '0;
        for (int i = 0; i < 8; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

endpackage

// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - multiplexed 7-segment refresh: one digit enabled per scan slot
module sseg_scan
    import reaction_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_BITS = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGITS-1:0][7:0] seg_pat,
    output logic [7:0]             sseg,
    output logic [7:0]             an
);

    logic [SCAN_BITS+2:0] scan_cnt;
    logic [2:0]           raw_idx;
    logic [2:0]           idx;
    logic [7:0]           pat;

    assign raw_idx = scan_cnt[SCAN_BITS+2:SCAN_BITS];
    assign idx     = 3'(int'(raw_idx) % DIGITS);

    always_comb begin
        pat = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) pat = seg_pat[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            sseg     <= 8'hFF;
            an       <= 8'hFF;
        end else begin
            scan_cnt <= scan_cnt + (SCAN_BITS+3)'(1);
            sseg     <= pat;
            an       <= ~(8'd1 << idx);
        end
    end

endmodule

// File: rtl/reaction_timer_mp.sv
// rtl/reaction_timer_mp.sv - multi-player reaction timer with false-start, timeout and best time
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int N_PLAYERS       = 2,
    parameter int MIN_DELAY_MS    = 2000,
    parameter int DELAY_SPAN_LOG2 = 12,
    parameter int TIMEOUT_MS      = 1000,
    parameter int DIGITS          = 4,
    parameter int SCAN_BITS       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [N_PLAYERS-1:0]  stop,
    input  logic                  show_best,
    output logic                  led,
    output logic [N_PLAYERS-1:0]  winner,
    output logic                  result_valid,
    output logic                  false_start,
    output logic                  timeout,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic [7:0]            sseg,
    output logic [7:0]            an
);

    localparam int TICK_DIV  = CLK_HZ / 1000;
    localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DELAY_MAX = MIN_DELAY_MS + (2 ** DELAY_SPAN_LOG2) - 1;
    localparam int DELAY_W   = $clog2(DELAY_MAX + 1);
    localparam int BW        = 4 * DIGITS;
    localparam logic [31:0]   TIMEOUT_BCD32 = to_bcd(TIMEOUT_MS);
    localparam logic [BW-1:0] TIMEOUT_BCD   = TIMEOUT_BCD32[BW-1:0];
    localparam logic [BW-1:0] BEST_INIT     = {DIGITS{4'h9}};

    state_t                 state;
    logic [15:0]            lfsr;
    logic [PRESC_W-1:0]     presc;
    logic [DELAY_W-1:0]     delay_cnt;
    logic [BW-1:0]          count_bcd;
    logic [BW-1:0]          bcd_next;
    logic                   carry;
    logic                   start_q;
    logic                   clear_q;
    logic [N_PLAYERS-1:0]   stop_q;
    logic                   start_edge;
    logic                   clear_edge;
    logic [N_PLAYERS-1:0]   stop_edge;
    logic [N_PLAYERS-1:0]   first_stop;
    logic                   tick;
    logic [DIGITS-1:0][7:0] seg_pat;

    assign start_edge = start & ~start_q;
    assign clear_edge = clear & ~clear_q;
    assign stop_edge  = stop & ~stop_q;
    // Isolates the lowest set bit: the lowest-index player wins a tie.
    assign first_stop = stop_edge & (~stop_edge + N_PLAYERS'(1));
    assign tick       = (presc == PRESC_W'(TICK_DIV - 1));

    always_comb begin
        bcd_next = count_bcd;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    bcd_next[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            presc        <= '0;
            delay_cnt    <= '0;
            count_bcd    <= '0;
            start_q      <= 1'b0;
            clear_q      <= 1'b0;
            stop_q       <= '0;
            led          <= 1'b0;
            winner       <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            result_bcd   <= '0;
            best_bcd     <= BEST_INIT;
        end else begin
            lfsr    <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
            start_q <= start;
            clear_q <= clear;
            stop_q  <= stop;
            presc   <= tick ? '0 : presc + PRESC_W'(1);

            if (clear_edge) begin
                state        <= IDLE;
                led          <= 1'b0;
                winner       <= '0;
                result_valid <= 1'b0;
                false_start  <= 1'b0;
                timeout      <= 1'b0;
                result_bcd   <= '0;
            end else begin
                case (state)
                    IDLE, DONE, FAULT: begin
                        if (start_edge) begin
                            state        <= WAIT;
                            delay_cnt    <= DELAY_W'(MIN_DELAY_MS)
                                          + DELAY_W'(lfsr[DELAY_SPAN_LOG2-1:0]);
                            presc        <= '0;
                            winner       <= '0;
                            result_valid <= 1'b0;
                            false_start  <= 1'b0;
                            timeout      <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (|stop_edge) begin
                            state       <= FAULT;
                            false_start <= 1'b1;
                            winner      <= first_stop;
                        end else if (tick) begin
                            if (delay_cnt <= DELAY_W'(1)) begin
                                state     <= TIMING;
                                led       <= 1'b1;
                                count_bcd <= '0;
                                presc     <= '0;
                            end else begin
                                delay_cnt <= delay_cnt - DELAY_W'(1);
                            end
                        end
                    end
                    TIMING: begin
                        // A stop wins over a tick landing in the same cycle.
                        if (|stop_edge) begin
                            state        <= DONE;
                            led          <= 1'b0;
                            result_bcd   <= count_bcd;
                            winner       <= first_stop;
                            result_valid <= 1'b1;
                            if (count_bcd < best_bcd) best_bcd <= count_bcd;
                        end else if (tick) begin
                            count_bcd <= bcd_next;
                            if (bcd_next == TIMEOUT_BCD) begin
                                state        <= DONE;
                                led          <= 1'b0;
                                timeout      <= 1'b1;
                                winner       <= '0;
                                result_valid <= 1'b1;
                                result_bcd   <= TIMEOUT_BCD;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        seg_pat = {DIGITS{SEG_BLANK}};
        for (int i = 0; i < DIGITS; i++) begin
            case (state)
                IDLE:    seg_pat[i] = show_best ? bcd_to_sseg(best_bcd[4*i +: 4])
                                    : ((i == 0) ? SEG_I : ((i == 1) ? SEG_H : SEG_BLANK));
                TIMING:  seg_pat[i] = bcd_to_sseg(count_bcd[4*i +: 4]);
                DONE:    seg_pat[i] = show_best ? bcd_to_sseg(best_bcd[4*i +: 4])
                                    : bcd_to_sseg(result_bcd[4*i +: 4]);
                FAULT:   seg_pat[i] = SEG_DASH;
                default: seg_pat[i] = SEG_BLANK;
            endcase
        end
    end

    sseg_scan #(
        .DIGITS    (DIGITS),
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .seg_pat (seg_pat),
        .sseg    (sseg),
        .an      (an)
    );

endmodule

// File: doc/reaction_timer_mp.md
Name: reaction_timer_mp

Overview:
Parametrised multi-player successor to the single-player reaction timer.
- Flow: a random delay runs, then the stimulus LED lights and per-millisecond BCD timing runs until the first player presses stop.
- Adds false-start detection, timeout, best-time memory and configurable digit count.
- Drives the board's multiplexed 7-segment display directly.
- Sits at top level beside the switch debouncers.

Parameters:
CLK_HZ, 100_000_000, clock frequency; ms tick period = CLK_HZ/1000 clocks (must divide exactly)
N_PLAYERS, 2, number of stop inputs (1..8)
MIN_DELAY_MS, 2000, minimum random delay
DELAY_SPAN_LOG2, 12, random extra delay 0..2^DELAY_SPAN_LOG2-1 ms
TIMEOUT_MS, 1000, reaction timeout; must be <= 10^DIGITS-1
DIGITS, 4, BCD digits counted/displayed (1..8)
SCAN_BITS, 17, display refresh: digit advances every 2^SCAN_BITS clocks

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  start request, debounced, level; rising edge acts
clear  in  1  return to idle, rising edge acts
stop  in  N_PLAYERS  per-player stop, debounced; rising edges act
show_best  in  1  level; in IDLE/DONE display best instead of result
led  out  1  stimulus LED
winner  out  N_PLAYERS  one-hot: first stopper, or false-starter
result_valid  out  1  result_bcd holds a completed measurement
false_start  out  1  stop pressed during delay
timeout  out  1  no stop within TIMEOUT_MS
result_bcd  out  4*DIGITS  last reaction time, ms, BCD
best_bcd  out  4*DIGITS  best (lowest) non-timeout time
sseg  out  8  segments active-low, bit7 = dp (always 1)
an  out  8  digit enables active-low; bits >= DIGITS always 1

Behaviour:
- Reset (rst=0, async): state IDLE; led=0, winner=0, result_valid=0, false_start=0, timeout=0, result_bcd=0, best_bcd=all 9s, sseg=8'hFF, an=8'hFF, LFSR=16'hACE1, scan counter=0.
- Edge detect: registered previous value of start/clear/stop; actions fire the cycle after the rising edge.
- LFSR: 16-bit maximal Galois, advances every clock, never zero. On the start edge, delay = MIN_DELAY_MS + lfsr[DELAY_SPAN_LOG2-1:0].
- Tick prescaler: cleared on entry to WAIT and TIMING. tick = 1 cycle every CLK_HZ/1000 clocks.
- States:
  - IDLE: start edge -> WAIT.
  - WAIT: led=0; count delay down per tick. At 0 -> TIMING, led=1 on the same edge, BCD counter=0.
    - Any stop edge in WAIT -> FAULT: false_start=1; winner = lowest-index pressing player.
  - TIMING: BCD counter +1 per tick, decimal carry across DIGITS.
    - Stop edge -> DONE: result_bcd = counter value; a tick in the same cycle is not counted. winner = lowest set index, result_valid=1, led=0.
    - Counter reaching TIMEOUT_MS -> DONE: timeout=1, winner=0, result_valid=1, result_bcd=TIMEOUT_MS.
  - DONE: if !timeout and result < best, best_bcd updates on the DONE entry edge.
  - DONE/FAULT: start edge -> WAIT; flags, winner and result_valid clear on that edge; best kept.
- Ignored inputs: start edge in WAIT/TIMING; stop edges in IDLE/DONE/FAULT.
- clear edge in any state -> IDLE: clears led, flags, winner, result_valid, result_bcd; best_bcd kept. clear beats a simultaneous start/stop.
- Display: registered sseg/an; digit index = scan counter[SCAN_BITS+2:SCAN_BITS] mod DIGITS.
  - IDLE: "HI" on digits 1,0, others blank; best shown if show_best.
  - WAIT: all blank.
  - TIMING: live counter.
  - DONE: result, or best if show_best.
  - FAULT: "-" on all digits.

Decomposition:
- Package reaction_pkg: state enum (IDLE, WAIT, TIMING, DONE, FAULT); segment constants SEG_H, SEG_I, SEG_DASH, SEG_BLANK; function bcd_to_sseg; LFSR tap constant.
- Sub-module sseg_scan: takes DIGITS x 8-bit segment patterns, produces sseg/an with the refresh counter.

Test Plan:
Bench params: CLK_HZ=10_000, MIN_DELAY_MS=5, DELAY_SPAN_LOG2=2, TIMEOUT_MS=50, DIGITS=4, SCAN_BITS=2, N_PLAYERS=2.
1. rst=0 then release -> all reset values; after one scan cycle, digit0 shows I, digit1 H, digits 2,3 blank.
2. start pulse -> led rises 50..80 clocks later; stop[1] 23 ticks after led -> result_bcd=16'h0023, winner=2'b10, result_valid=1, best_bcd=16'h0023.
3. start, then stop[0] before led -> false_start=1, winner=2'b01, led stays 0, all digits "-".
4. start, no stop -> after 50 ticks timeout=1, result_bcd=16'h0050, best_bcd unchanged.
5. stop[0] and stop[1] in the same cycle at 30 ms -> winner=2'b01, best stays 0023; a later 12 ms run -> best_bcd=16'h0012.
6. rst=0 mid-TIMING -> led=0 and best_bcd=16'h9999 immediately (asynchronous, no clock edge); clear mid-WAIT -> IDLE, best kept, no led.
